fft_sample_buffer: RTL
======================

// Module: fft_sample_buffer
// PURPOSE
//   Ping-pong (double) sample buffer feeding the FFT controller. Accepts a continuous
//   audio sample stream into a write bank; when FFT_POINTS samples are captured and the
//   read bank is free, swaps banks and raises o_data_ready. The FFT controller then reads
//   the frame by address. Frames arriving while the reader still holds a bank are dropped.
// PARAMETERS
//   FFT_POINTS  512  samples per frame; power of two, >= 4
//   DATA_WIDTH  24   sample width, two's complement
// PORTS
//   clk              in   1                     clock
//   reset            in   1                     synchronous, active-high reset
//   i_sample_valid   in   1                     i_sample is accepted on this clk edge
//   i_sample         in   DATA_WIDTH            audio sample
//   i_read_addr      in   $clog2(FFT_POINTS)    frame read address (natural order)
//   o_read_data      out  DATA_WIDTH            read-bank word at i_read_addr
//   i_fft_busy       in   1                     FFT controller busy (its o_fft_busy)
//   o_data_ready     out  1                     full frame available in read bank
//   o_overrun        out  1                     1-cycle pulse: completed frame dropped
//   o_overrun_count  out  8                     dropped frames, saturates at 255
//   o_fill_level     out  $clog2(FFT_POINTS)+1  samples in current write bank
//   o_wr_bank        out  1                     index of current write bank
// BEHAVIOUR
// - Reset: o_data_ready=0, o_overrun=0, o_overrun_count=0, o_fill_level=0, o_wr_bank=0,
//   reader state FREE. RAM contents are not cleared; o_read_data undefined until first frame.
// - Storage: 2 x FFT_POINTS x DATA_WIDTH. Write is synchronous; read is combinational
//   (o_read_data follows i_read_addr same cycle) because the controller writes its working
//   RAM in the same cycle it presents the address.
// - Write: each edge with i_sample_valid stores i_sample at [o_wr_bank][wr_ptr], wr_ptr++.
//   Gaps in i_sample_valid are allowed; nothing advances without valid.
// - Frame complete = valid accepted with wr_ptr==FFT_POINTS-1. On that edge, wr_ptr->0 and:
//   * reader FREE (or releasing this cycle, see below): rd_bank<=o_wr_bank, o_wr_bank
//     toggles, reader->ANNOUNCED.
//   * reader ANNOUNCED/READING: frame dropped, o_wr_bank unchanged (bank is rewritten),
//     o_overrun=1 next cycle only, o_overrun_count++ (saturating).
// - o_fill_level = wr_ptr (0..FFT_POINTS-1 in practice; one extra bit for headroom).
// - Reader FSM (registered):
//   FREE      : o_data_ready=0. Frame complete -> ANNOUNCED.
//   ANNOUNCED : o_data_ready=1 (level). i_fft_busy==1 sampled -> READING.
//   READING   : o_data_ready=0. i_fft_busy==0 sampled -> FREE (bank released).
//   Unused encoding -> FREE.
// - Latency: o_data_ready high on the edge after the final sample is accepted; falls on the
//   edge after i_fft_busy is first sampled high (one overlap cycle is harmless: controller
//   ignores ready while loading).
// - Simultaneous: frame complete in same cycle as READING sees busy low -> release wins,
//   swap occurs, reader->ANNOUNCED directly (no overrun).
// - Read bank is never written while ANNOUNCED or READING; o_read_data stable for the frame.
// - Reset mid-fill or mid-read: partial frame discarded, reader FREE, o_data_ready drops
//   next edge; controller must be reset alongside.
// TESTING
// 1. Reset asserted 3 cycles -> all outputs 0, o_fill_level=0, o_wr_bank=0.
// 2. 512 consecutive valid samples 0..511, busy=0 -> o_data_ready=1 next edge, o_wr_bank=1;
//    i_read_addr=k returns k for k=0,255,511; assert busy -> ready=0 next edge.
// 3. Hold busy=1 after frame 1, stream 512 more samples -> o_overrun pulse 1 cycle,
//    o_overrun_count=1, ready stays 0, addr 7 still returns 7; 255 more drops -> count stays 255.
// 4. Drop busy on same edge as 512th sample of frame 2 (values 1000+k) -> ready=1 next edge,
//    no overrun, addr 3 returns 1003.
// 5. Valid every 4th cycle, 10 samples -> o_fill_level=10 after 40 cycles, no ready.
// 6. Reset after 100 samples, then 512 samples 0..511 -> single ready, addr 0 returns 0.

Source files
------------

// File: rtl/fft_sample_buffer.sv
// rtl/fft_sample_buffer.sv - ping-pong frame buffer between the audio sample stream and the FFT controller
// The write bank fills continuously; a completed frame swaps banks only when the reader has released its bank.
module fft_sample_buffer #(
  parameter int FFT_POINTS = 512,
  parameter int DATA_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_sample_valid,
  input  logic [DATA_WIDTH-1:0]         i_sample,
  input  logic [$clog2(FFT_POINTS)-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0]         o_read_data,
  input  logic                          i_fft_busy,
  output logic                          o_data_ready,
  output logic                          o_overrun,
  output logic [7:0]                    o_overrun_count,
  output logic [$clog2(FFT_POINTS):0]   o_fill_level,
  output logic                          o_wr_bank
);

  localparam int AW = $clog2(FFT_POINTS);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_ANNOUNCED = 2'd1,
    ST_READING   = 2'd2
  } rd_state_t;

  rd_state_t             rd_state;
  logic [AW-1:0]         wr_ptr;
  logic                  rd_bank;
  logic [DATA_WIDTH-1:0] mem [0:2*FFT_POINTS-1];

  logic frame_done;
  logic release_now;
  logic can_swap;

  assign frame_done  = i_sample_valid && (wr_ptr == AW'(FFT_POINTS - 1));
  // A reader finishing on the same edge as the last sample still frees its bank in time.
  assign release_now = (rd_state == ST_READING) && !i_fft_busy;
  assign can_swap    = (rd_state == ST_FREE) || release_now;

  // Only the write bank is ever addressed for writes, so the read bank stays stable.
  always_ff @(posedge clk) begin
    if (!reset && i_sample_valid) begin
      mem[{o_wr_bank, wr_ptr}] <= i_sample;
    end
  end

  assign o_read_data  = mem[{rd_bank, i_read_addr}];
  assign o_fill_level = {1'b0, wr_ptr};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state        <= ST_FREE;
      wr_ptr          <= '0;
      rd_bank         <= 1'b0;
      o_wr_bank       <= 1'b0;
      o_data_ready    <= 1'b0;
      o_overrun       <= 1'b0;
      o_overrun_count <= 8'd0;
    end else begin
      o_overrun <= 1'b0;
      if (i_sample_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (frame_done && can_swap) begin
        rd_bank      <= o_wr_bank;
        o_wr_bank    <= ~o_wr_bank;
        rd_state     <= ST_ANNOUNCED;
        o_data_ready <= 1'b1;
      end else begin
        if (frame_done) begin
          o_overrun <= 1'b1;
          if (o_overrun_count != 8'hFF) begin
            o_overrun_count <= o_overrun_count + 8'd1;
          end
        end
        case (rd_state)
          ST_FREE: begin
            o_data_ready <= 1'b0;
          end
          ST_ANNOUNCED: begin
            if (i_fft_busy) begin
              rd_state     <= ST_READING;
              o_data_ready <= 1'b0;
            end else begin
              o_data_ready <= 1'b1;
            end
          end
          ST_READING: begin
            o_data_ready <= 1'b0;
            if (!i_fft_busy) begin
              rd_state <= ST_FREE;
            end
          end
          default: begin
            rd_state     <= ST_FREE;
            o_data_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
